// File: rtl/cic_integrator_bank.sv
// cic_integrator_bank
//   Cascade of NUM_STAGES registered integrators for the CIC decimator
//   datapath. Each stage keeps one accumulator per time-multiplexed channel.
//   Arithmetic wraps modulo 2^ACC_WIDTH, which CIC correctness depends on.
//
// Ports
//   clk            clock
//   reset_n        asynchronous active-low reset of all state
//   clear          synchronous clear of all state; beats inp_samp_str
//   inp_samp_data  signed input sample (DATA_WIDTH_INP)
//   inp_samp_str   input sample valid, one cycle per sample
//   out_samp_data  last-stage accumulator MSBs (DATA_WIDTH_OUT), held between strobes
//   out_samp_str   output valid, NUM_STAGES cycles after the input strobe
//   out_samp_chan  channel tag of the current output
module cic_integrator_bank #(
  parameter int DATA_WIDTH_INP = 16,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int NUM_STAGES     = 3,
  parameter int NUM_CHANNELS   = 1,
  parameter int CHAN_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [DATA_WIDTH_INP-1:0] inp_samp_data,
  input  logic                      inp_samp_str,
  output logic [DATA_WIDTH_OUT-1:0] out_samp_data,
  output logic                      out_samp_str,
  output logic [CHAN_WIDTH-1:0]     out_samp_chan
);

  localparam int ACC_WIDTH = (DATA_WIDTH_INP > DATA_WIDTH_OUT) ? DATA_WIDTH_INP : DATA_WIDTH_OUT;

  typedef logic [ACC_WIDTH-1:0]  acc_t;
  typedef logic [CHAN_WIDTH-1:0] chan_t;

  chan_t chan_cnt;
  acc_t  samp_ext;

  // Per-stage, per-channel accumulators.
  acc_t  acc       [NUM_STAGES][NUM_CHANNELS];

  // Registered stage outputs (stage k lives at index k-1).
  logic  stg_valid [NUM_STAGES];
  chan_t stg_tag   [NUM_STAGES];
  acc_t  stg_val   [NUM_STAGES];

  // Inputs feeding each stage: the sample port for the first, the previous
  // stage's registers for the rest.
  logic  in_valid  [NUM_STAGES];
  chan_t in_tag    [NUM_STAGES];
  acc_t  in_val    [NUM_STAGES];

  assign samp_ext = ACC_WIDTH'($signed(inp_samp_data));

  always_comb begin
    in_valid[0] = inp_samp_str;
    in_tag[0]   = chan_cnt;
    in_val[0]   = samp_ext;
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      in_valid[k] = stg_valid[k-1];
      in_tag[k]   = stg_tag[k-1];
      in_val[k]   = stg_val[k-1];
    end
  end

  // Input channel counter: tags each accepted strobe, wraps at NUM_CHANNELS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_cnt <= '0;
    end else if (clear) begin
      chan_cnt <= '0;
    end else if (inp_samp_str) begin
      if (chan_cnt == chan_t'(NUM_CHANNELS - 1))
        chan_cnt <= '0;
      else
        chan_cnt <= chan_cnt + chan_t'(1);
    end
  end

  // Integrator pipeline. Each stage reads its own accumulator registered on
  // the previous edge, so back-to-back updates of one channel need no bypass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        stg_valid[k] <= 1'b0;
        stg_tag[k]   <= '0;
        stg_val[k]   <= '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++)
          acc[k][c] <= '0;
      end
    end else if (clear) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        stg_valid[k] <= 1'b0;
        stg_tag[k]   <= '0;
        stg_val[k]   <= '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++)
          acc[k][c] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        stg_valid[k] <= in_valid[k];
        if (in_valid[k]) begin
          stg_tag[k] <= in_tag[k];
          for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (in_tag[k] == chan_t'(c)) begin
              acc[k][c]  <= acc[k][c] + in_val[k];
              stg_val[k] <= acc[k][c] + in_val[k];
            end
          end
        end
      end
    end
  end

  assign out_samp_data = stg_val[NUM_STAGES-1][ACC_WIDTH-1 -: DATA_WIDTH_OUT];
  assign out_samp_str  = stg_valid[NUM_STAGES-1];
  assign out_samp_chan = stg_tag[NUM_STAGES-1];

endmodule
